par_class_buf: RTL and testbench
================================

Name: par_class_buf

Overview:
- Parametrised, multi-channel successor to the single-stream parser-to-classifier hand-off.
- Accepts NUM_CH independent parser streams. Each stream carries parser results and the later-arriving tail info, which are buffered separately in per-channel FIFOs.
- A channel's header and tail are paired and round-robin arbitrated onto one registered valid/ready output to the classifier.
- The block also pipelines the management replication (rpl) buses by one cycle in each direction.

Parameters:
- NUM_CH, 4, number of parser input channels (1..8)
- DEPTH, 4, entries per header FIFO and per tail FIFO, per channel (2..16, power of two)
- PAR_W, 512, width of one parser_out result
- TAIL_W, 64, width of one tail_info record
- FRWD_W, 32, width of rpl_frwd
- BKWD_W, 8, width of rpl_bkwd

Ports:
- cclk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_par  in  NUM_CH*PAR_W  per-channel parser results, channel c at [c*PAR_W +: PAR_W]
- in_par_v  in  NUM_CH  per-channel result push
- in_par_rdy  out  NUM_CH  header FIFO of channel c can accept
- in_tail  in  NUM_CH*TAIL_W  per-channel tail info
- in_tail_v  in  NUM_CH  per-channel tail push
- in_tail_rdy  out  NUM_CH  tail FIFO of channel c can accept
- out_par  out  PAR_W  paired parser result to classifier
- out_tail  out  TAIL_W  paired tail info
- out_ch  out  $clog2(NUM_CH) (min 1)  source channel
- out_v  out  1  output valid
- out_rdy  in  1  classifier accepts
- rpl_frwd_in  in  FRWD_W  management from upstream
- rpl_frwd  out  FRWD_W  management to classifier, one-cycle delayed
- rpl_bkwd_in  in  BKWD_W  status from classifier
- rpl_bkwd  out  BKWD_W  status to parser, one-cycle delayed
- err_clr  in  1  clears err_ovf
- err_ovf  out  NUM_CH  sticky overflow, per channel

Behaviour:
- Reset (rst_n=0 at a cclk edge):
  - All FIFO counts and pointers go to 0.
  - out_v=0; out_par, out_tail, out_ch, rpl_frwd, rpl_bkwd and err_ovf all 0.
  - RR pointer = NUM_CH-1, so channel 0 has first priority.
  - in_par_rdy=in_tail_rdy=0 while rst_n=0; they rise to 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all buffered entries and any pending out_v.
- Ready and occupancy:
  - in_par_rdy[c] = (hdr_cnt[c] < DEPTH) from registered count; likewise in_tail_rdy[c] from tail_cnt[c].
  - No write-through: a full FIFO deasserts ready even if it is popped in the same cycle.
- Push: in_par_v[c]&in_par_rdy[c] writes the header FIFO at the edge; tail push is analogous.
- Overflow:
  - A push while not ready is dropped; the FIFO is unchanged and err_ovf[c] is set next cycle.
  - err_ovf[c] holds until err_clr=1. If set and clear coincide, set wins.
- Eligibility: channel c is eligible when hdr_cnt[c]>0 and tail_cnt[c]>0, using registered counts.
  - A header without a tail waits indefinitely; the reverse also waits.
- Arbitration:
  - When load = (!out_v | out_rdy) and any channel is eligible, grant the first eligible channel searching from RR+1 upward modulo NUM_CH.
  - On grant: pop that channel's header and tail together, load out_par/out_tail/out_ch, set out_v=1, and set RR=granted channel.
  - When load and nothing is eligible: out_v=0.
  - When out_v & !out_rdy: all outputs hold stable and no pops occur.
- Latency:
  - Header and tail both pushed at edge N gives out_v=1 in cycle N+1 (counts update at N; output register loads at N+1).
  - Sustained throughput is one pair per cycle with out_rdy=1.
- Simultaneous push and pop on one FIFO: the count is unchanged and the pointers both advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- rpl_frwd/rpl_bkwd are plain registers of their inputs with no stall interaction.
- Ordering: per channel, pairs are output in FIFO order (k-th header with k-th tail). There is no ordering across channels beyond round-robin.

Test Plan:
- Reset then push ch0 hdr=0xA1, tail=0xB1 in the same cycle -> out_v=1 one cycle later with out_ch=0, out_par=0xA1, out_tail=0xB1; out_v=0 the following cycle.
- ch2 hdr at cycle 0, tail at cycle 5 -> out_v stays 0 through cycle 5 and rises in cycle 6 with out_ch=2.
- All 4 channels hold pairs, out_rdy=1 -> out_ch sequence 0,1,2,3,0,...; after a ch1-only grant, ch1 and ch2 eligible -> ch2 next.
- out_rdy=0 for 10 cycles with DEPTH=4 -> after 4 header pushes in_par_rdy[0]=0, out_* held; a 5th push forced -> dropped, err_ovf[0]=1; err_clr -> 0; set and clear in the same cycle -> 1.
- rst_n low for 1 cycle with 3 pairs buffered and out_v=1 -> out_v=0, counts 0, no stale output after reset; rpl_frwd_in=0x1234 -> rpl_frwd=0x1234 one cycle later.
- NUM_CH=1, DEPTH=2 build: back-to-back pairs with out_rdy=1 -> one output per cycle, FIFO order preserved across pointer wrap (8 pairs).

Source files
------------

// File: rtl/par_class_buf.sv
// Multi-channel parser-to-classifier buffer: per-channel header and tail FIFOs,
// paired round-robin onto one registered valid/ready output, plus rpl pipelining.
module par_class_buf #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int PAR_W  = 512,
  parameter int TAIL_W = 64,
  parameter int FRWD_W = 32,
  parameter int BKWD_W = 8,
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic [NUM_CH*PAR_W-1:0]  in_par,
  input  logic [NUM_CH-1:0]        in_par_v,
  output logic [NUM_CH-1:0]        in_par_rdy,
  input  logic [NUM_CH*TAIL_W-1:0] in_tail,
  input  logic [NUM_CH-1:0]        in_tail_v,
  output logic [NUM_CH-1:0]        in_tail_rdy,
  output logic [PAR_W-1:0]         out_par,
  output logic [TAIL_W-1:0]        out_tail,
  output logic [CHW-1:0]           out_ch,
  output logic                     out_v,
  input  logic                     out_rdy,
  input  logic [FRWD_W-1:0]        rpl_frwd_in,
  output logic [FRWD_W-1:0]        rpl_frwd,
  input  logic [BKWD_W-1:0]        rpl_bkwd_in,
  output logic [BKWD_W-1:0]        rpl_bkwd,
  input  logic                     err_clr,
  output logic [NUM_CH-1:0]        err_ovf
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [NUM_CH-1:0] elig, pop, hdrPush, tailPush, ovfSet;
  logic [PAR_W-1:0]  hdrHead  [NUM_CH];
  logic [TAIL_W-1:0] tailHead [NUM_CH];

  logic              outV_q;
  logic [PAR_W-1:0]  outPar_q;
  logic [TAIL_W-1:0] outTail_q;
  logic [CHW-1:0]    outCh_q, rr_q, grantCh;
  logic              grantValid, load;
  logic [FRWD_W-1:0] frwd_q;
  logic [BKWD_W-1:0] bkwd_q;
  logic [NUM_CH-1:0] errOvf_q;

  assign hdrPush  = in_par_v  & in_par_rdy;
  assign tailPush = in_tail_v & in_tail_rdy;
  assign ovfSet   = (in_par_v & ~in_par_rdy) | (in_tail_v & ~in_tail_rdy);

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic [PAR_W-1:0]  hdrMem_q  [DEPTH];
    logic [TAIL_W-1:0] tailMem_q [DEPTH];
    logic [PTRW-1:0]   hdrWr_q, hdrRd_q, tailWr_q, tailRd_q;
    logic [CNTW-1:0]   hdrCnt_q, hdrCnt_d, tailCnt_q, tailCnt_d;

    // Ready comes only from the registered count, so a full FIFO stays closed
    // even in the cycle it is being popped.
    assign in_par_rdy[c]  = rst_n & (hdrCnt_q  < CNTW'(DEPTH));
    assign in_tail_rdy[c] = rst_n & (tailCnt_q < CNTW'(DEPTH));
    assign elig[c]        = (hdrCnt_q != '0) && (tailCnt_q != '0);
    assign hdrHead[c]     = hdrMem_q[hdrRd_q];
    assign tailHead[c]    = tailMem_q[tailRd_q];

    always_comb begin
      hdrCnt_d  = hdrCnt_q;
      tailCnt_d = tailCnt_q;
      if (hdrPush[c] && !pop[c])       hdrCnt_d = hdrCnt_q + CNTW'(1);
      else if (!hdrPush[c] && pop[c])  hdrCnt_d = hdrCnt_q - CNTW'(1);
      if (tailPush[c] && !pop[c])      tailCnt_d = tailCnt_q + CNTW'(1);
      else if (!tailPush[c] && pop[c]) tailCnt_d = tailCnt_q - CNTW'(1);
    end

    always_ff @(posedge cclk) begin
      if (!rst_n) begin
        hdrWr_q   <= '0;
        hdrRd_q   <= '0;
        tailWr_q  <= '0;
        tailRd_q  <= '0;
        hdrCnt_q  <= '0;
        tailCnt_q <= '0;
      end else begin
        if (hdrPush[c])  hdrWr_q  <= hdrWr_q  + PTRW'(1);
        if (tailPush[c]) tailWr_q <= tailWr_q + PTRW'(1);
        if (pop[c]) begin
          hdrRd_q  <= hdrRd_q  + PTRW'(1);
          tailRd_q <= tailRd_q + PTRW'(1);
        end
        hdrCnt_q  <= hdrCnt_d;
        tailCnt_q <= tailCnt_d;
      end
    end

    always_ff @(posedge cclk) begin
      if (hdrPush[c])  hdrMem_q[hdrWr_q]   <= in_par[c*PAR_W +: PAR_W];
      if (tailPush[c]) tailMem_q[tailWr_q] <= in_tail[c*TAIL_W +: TAIL_W];
    end
  end

  function automatic logic [CHW-1:0] nextCh(input logic [CHW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return CHW'(sum);
  endfunction

  assign load = !outV_q || out_rdy;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    grantValid = 1'b0;
    grantCh    = rr_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!grantValid && elig[nextCh(rr_q, i)]) begin
        grantValid = 1'b1;
        grantCh    = nextCh(rr_q, i);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grantValid) pop[grantCh] = 1'b1;
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      outV_q    <= 1'b0;
      outPar_q  <= '0;
      outTail_q <= '0;
      outCh_q   <= '0;
      rr_q      <= CHW'(NUM_CH - 1);
    end else if (load) begin
      outV_q <= grantValid;
      if (grantValid) begin
        outPar_q  <= hdrHead[grantCh];
        outTail_q <= tailHead[grantCh];
        outCh_q   <= grantCh;
        rr_q      <= grantCh;
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      frwd_q   <= '0;
      bkwd_q   <= '0;
      errOvf_q <= '0;
    end else begin
      frwd_q   <= rpl_frwd_in;
      bkwd_q   <= rpl_bkwd_in;
      errOvf_q <= ovfSet | (errOvf_q & {NUM_CH{~err_clr}});
    end
  end

  assign out_v    = outV_q;
  assign out_par  = outPar_q;
  assign out_tail = outTail_q;
  assign out_ch   = outCh_q;
  assign rpl_frwd = frwd_q;
  assign rpl_bkwd = bkwd_q;
  assign err_ovf  = errOvf_q;

endmodule

// File: tb/tb_par_class_buf.sv
// Directed bench for par_class_buf: a 4-channel build checked through per-channel
// expected queues, plus a 1-channel DEPTH=2 build for pointer-wrap ordering.
module tb_par_class_buf;
  localparam int NCH = 4;
  localparam int PW  = 512;
  localparam int TW  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH*PW-1:0] in_par;
  logic [NCH-1:0]    in_par_v, in_par_rdy;
  logic [NCH*TW-1:0] in_tail;
  logic [NCH-1:0]    in_tail_v, in_tail_rdy;
  logic [PW-1:0]     out_par;
  logic [TW-1:0]     out_tail;
  logic [1:0]        out_ch;
  logic              out_v, out_rdy;
  logic [31:0]       rpl_frwd_in, rpl_frwd;
  logic [7:0]        rpl_bkwd_in, rpl_bkwd;
  logic              err_clr;
  logic [NCH-1:0]    err_ovf;

  logic [15:0] s1_in_par, s1_out_par;
  logic [7:0]  s1_in_tail, s1_out_tail;
  logic        s1_in_par_v, s1_in_par_rdy, s1_in_tail_v, s1_in_tail_rdy;
  logic [0:0]  s1_out_ch;
  logic        s1_out_v, s1_out_rdy;
  logic [7:0]  s1_frwd_in, s1_frwd, s1_bkwd_in, s1_bkwd;
  logic        s1_err_clr;
  logic [0:0]  s1_err_ovf;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] expPar  [NCH][$];
  logic [TW-1:0] expTail [NCH][$];
  logic [15:0]   s1Par[$];
  logic [7:0]    s1Tail[$];

  par_class_buf #(.NUM_CH(4), .DEPTH(4), .PAR_W(PW), .TAIL_W(TW), .FRWD_W(32), .BKWD_W(8)) dut (
    .cclk(clk), .rst_n(rst_n),
    .in_par(in_par), .in_par_v(in_par_v), .in_par_rdy(in_par_rdy),
    .in_tail(in_tail), .in_tail_v(in_tail_v), .in_tail_rdy(in_tail_rdy),
    .out_par(out_par), .out_tail(out_tail), .out_ch(out_ch), .out_v(out_v), .out_rdy(out_rdy),
    .rpl_frwd_in(rpl_frwd_in), .rpl_frwd(rpl_frwd), .rpl_bkwd_in(rpl_bkwd_in), .rpl_bkwd(rpl_bkwd),
    .err_clr(err_clr), .err_ovf(err_ovf)
  );

  par_class_buf #(.NUM_CH(1), .DEPTH(2), .PAR_W(16), .TAIL_W(8), .FRWD_W(8), .BKWD_W(8)) dut1 (
    .cclk(clk), .rst_n(rst_n),
    .in_par(s1_in_par), .in_par_v(s1_in_par_v), .in_par_rdy(s1_in_par_rdy),
    .in_tail(s1_in_tail), .in_tail_v(s1_in_tail_v), .in_tail_rdy(s1_in_tail_rdy),
    .out_par(s1_out_par), .out_tail(s1_out_tail), .out_ch(s1_out_ch), .out_v(s1_out_v), .out_rdy(s1_out_rdy),
    .rpl_frwd_in(s1_frwd_in), .rpl_frwd(s1_frwd), .rpl_bkwd_in(s1_bkwd_in), .rpl_bkwd(s1_bkwd),
    .err_clr(s1_err_clr), .err_ovf(s1_err_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one channel's header and/or tail for the next edge and records what
  // the classifier side must later see for that channel.
  task automatic applyStimulus(input int ch, input bit doHdr, input bit doTail,
                               input logic [63:0] hv, input logic [63:0] tv);
    if (doHdr) begin
      in_par[ch*PW +: PW] = {8{hv}};
      in_par_v[ch] = 1'b1;
      expPar[ch].push_back({8{hv}});
    end
    if (doTail) begin
      in_tail[ch*TW +: TW] = tv;
      in_tail_v[ch] = 1'b1;
      expTail[ch].push_back(tv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_par_v     = '0;
    in_tail_v    = '0;
    s1_in_par_v  = 1'b0;
    s1_in_tail_v = 1'b0;
  endtask

  function automatic int pending();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += expPar[c].size() + expTail[c].size();
    return n;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    checkOutput("drain_empty", PW'(pending()), '0);
  endtask

  // Every accepted output is matched against the front of its channel's queue.
  always @(negedge clk) begin
    if (rst_n && out_v && out_rdy) begin
      checkOutput("sb_hdr_present", PW'(expPar[out_ch].size() > 0), PW'(1));
      checkOutput("sb_tail_present", PW'(expTail[out_ch].size() > 0), PW'(1));
      if (expPar[out_ch].size() > 0) checkOutput("sb_par", out_par, expPar[out_ch].pop_front());
      if (expTail[out_ch].size() > 0) checkOutput("sb_tail", PW'(out_tail), PW'(expTail[out_ch].pop_front()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rrSeq [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    rst_n = 1'b0; in_par = '0; in_par_v = '0; in_tail = '0; in_tail_v = '0;
    out_rdy = 1'b1; rpl_frwd_in = '0; rpl_bkwd_in = '0; err_clr = 1'b0;
    s1_in_par = '0; s1_in_par_v = 1'b0; s1_in_tail = '0; s1_in_tail_v = 1'b0;
    s1_out_rdy = 1'b1; s1_frwd_in = '0; s1_bkwd_in = '0; s1_err_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_out_v", PW'(out_v), '0);
    checkOutput("rst_out_par", out_par, '0);
    checkOutput("rst_out_tail", PW'(out_tail), '0);
    checkOutput("rst_out_ch", PW'(out_ch), '0);
    checkOutput("rst_err_ovf", PW'(err_ovf), '0);
    checkOutput("rst_rpl", PW'({rpl_frwd, rpl_bkwd}), '0);
    checkOutput("rst_rdy_low", PW'({in_par_rdy, in_tail_rdy}), '0);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_rst", PW'({in_par_rdy, in_tail_rdy}), PW'(8'hFF));

    $display("[TB] single pair latency");
    applyStimulus(0, 1, 1, 64'hA1, 64'hB1);
    step();
    checkOutput("lat_not_yet", PW'(out_v), '0);
    step();
    checkOutput("lat_out_v", PW'(out_v), PW'(1));
    checkOutput("lat_out_ch", PW'(out_ch), '0);
    checkOutput("lat_out_par", out_par, {8{64'hA1}});
    checkOutput("lat_out_tail", PW'(out_tail), PW'(64'hB1));
    step();
    checkOutput("lat_out_v_drop", PW'(out_v), '0);

    $display("[TB] header waits for tail");
    applyStimulus(2, 1, 0, 64'hC2, 64'h0);
    step();
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput("wait_tail_v", PW'(out_v), '0);
    end
    applyStimulus(2, 0, 1, 64'h0, 64'hD2);
    step();
    checkOutput("wait_tail_edge_v", PW'(out_v), '0);
    step();
    checkOutput("wait_tail_out_v", PW'(out_v), PW'(1));
    checkOutput("wait_tail_out_ch", PW'(out_ch), PW'(2));
    step();

    $display("[TB] round robin");
    for (int c = 0; c < NCH; c++) applyStimulus(c, 1, 1, 64'h100 + 64'(c), 64'h200 + 64'(c));
    step();
    for (int c = 0; c < NCH; c++) applyStimulus(c, 1, 1, 64'h300 + 64'(c), 64'h400 + 64'(c));
    step();
    for (int i = 0; i < 8; i++) begin
      checkOutput("rr_v", PW'(out_v), PW'(1));
      checkOutput("rr_ch", PW'(out_ch), PW'(rrSeq[i]));
      step();
    end
    checkOutput("rr_idle", PW'(out_v), '0);
    applyStimulus(1, 1, 1, 64'h510, 64'h610);
    step();
    applyStimulus(1, 1, 1, 64'h511, 64'h611);
    applyStimulus(2, 1, 1, 64'h520, 64'h620);
    step();
    checkOutput("rr_only_ch1", PW'(out_ch), PW'(1));
    step();
    checkOutput("rr_ch2_next", PW'(out_ch), PW'(2));
    step();
    checkOutput("rr_ch1_again", PW'(out_ch), PW'(1));
    step();
    checkOutput("rr_idle2", PW'(out_v), '0);

    $display("[TB] stall and overflow");
    out_rdy = 1'b0;
    applyStimulus(3, 1, 1, 64'hC3, 64'hD3);
    step();
    step();
    checkOutput("stall_v", PW'(out_v), PW'(1));
    checkOutput("stall_ch", PW'(out_ch), PW'(3));
    for (int k = 0; k < 4; k++) begin
      checkOutput("fill_rdy_open", PW'(in_par_rdy[0]), PW'(1));
      applyStimulus(0, 1, 1, 64'hE0 + 64'(k), 64'hF0 + 64'(k));
      step();
      checkOutput("stall_hold_v", PW'(out_v), PW'(1));
      checkOutput("stall_hold_par", out_par, {8{64'hC3}});
    end
    checkOutput("full_par_rdy", PW'(in_par_rdy), PW'(4'b1110));
    checkOutput("full_tail_rdy", PW'(in_tail_rdy), PW'(4'b1110));
    checkOutput("ovf_before", PW'(err_ovf), '0);
    in_par[0 +: PW] = {8{64'hDEAD}};
    in_par_v[0] = 1'b1;
    step();
    checkOutput("ovf_set", PW'(err_ovf), PW'(4'b0001));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("ovf_clr", PW'(err_ovf), '0);
    in_par_v[0] = 1'b1;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("ovf_set_wins", PW'(err_ovf), PW'(4'b0001));
    step();
    checkOutput("ovf_sticky", PW'(err_ovf), PW'(4'b0001));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checkOutput("ovf_clr2", PW'(err_ovf), '0);
    out_rdy = 1'b1;
    waitDrain(20);
    step();
    checkOutput("drain_idle", PW'(out_v), '0);
    checkOutput("drain_rdy", PW'(in_par_rdy), PW'(4'hF));

    $display("[TB] reset mid operation");
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) applyStimulus(c, 1, 1, 64'h50 + 64'(c), 64'h60 + 64'(c));
    step();
    step();
    checkOutput("mid_v_before", PW'(out_v), PW'(1));
    rst_n = 1'b0;
    step();
    checkOutput("mid_rst_v", PW'(out_v), '0);
    checkOutput("mid_rst_par", out_par, '0);
    checkOutput("mid_rst_rdy", PW'(in_par_rdy), '0);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      expPar[c].delete();
      expTail[c].delete();
    end
    out_rdy = 1'b1;
    #1;
    checkOutput("mid_rdy_back", PW'({in_par_rdy, in_tail_rdy}), PW'(8'hFF));
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mid_no_stale", PW'(out_v), '0);
    end
    applyStimulus(1, 1, 1, 64'h77, 64'h88);
    step();
    step();
    checkOutput("mid_fresh_v", PW'(out_v), PW'(1));
    checkOutput("mid_fresh_ch", PW'(out_ch), PW'(1));
    checkOutput("mid_fresh_par", out_par, {8{64'h77}});
    step();
    checkOutput("mid_fresh_drop", PW'(out_v), '0);

    $display("[TB] rpl pipelining");
    rpl_frwd_in = 32'h1234;
    rpl_bkwd_in = 8'h5A;
    #1;
    checkOutput("rpl_frwd_delay", PW'(rpl_frwd), '0);
    step();
    checkOutput("rpl_frwd", PW'(rpl_frwd), PW'(32'h1234));
    checkOutput("rpl_bkwd", PW'(rpl_bkwd), PW'(8'h5A));
    rpl_frwd_in = 32'hCAFE0001;
    rpl_bkwd_in = 8'hA5;
    step();
    checkOutput("rpl_frwd2", PW'(rpl_frwd), PW'(32'hCAFE0001));
    checkOutput("rpl_bkwd2", PW'(rpl_bkwd), PW'(8'hA5));

    $display("[TB] single channel depth 2 wrap");
    for (int k = 0; k < 8; k++) begin
      checkOutput("s1_rdy", PW'({s1_in_par_rdy, s1_in_tail_rdy}), PW'(2'b11));
      s1_in_par = 16'hA000 + 16'(k);
      s1_in_tail = 8'h50 + 8'(k);
      s1_in_par_v = 1'b1;
      s1_in_tail_v = 1'b1;
      s1Par.push_back(16'hA000 + 16'(k));
      s1Tail.push_back(8'h50 + 8'(k));
      step();
      if (k > 0) begin
        checkOutput("s1_v", PW'(s1_out_v), PW'(1));
        checkOutput("s1_ch", PW'(s1_out_ch), '0);
        checkOutput("s1_par", PW'(s1_out_par), PW'(s1Par.pop_front()));
        checkOutput("s1_tail", PW'(s1_out_tail), PW'(s1Tail.pop_front()));
      end
    end
    step();
    checkOutput("s1_v_last", PW'(s1_out_v), PW'(1));
    checkOutput("s1_par_last", PW'(s1_out_par), PW'(s1Par.pop_front()));
    checkOutput("s1_tail_last", PW'(s1_out_tail), PW'(s1Tail.pop_front()));
    step();
    checkOutput("s1_idle", PW'(s1_out_v), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
